// File: rtl/axi_lrsc_reservation_tracker_pkg.sv
// Shared types and helpers for the LR/SC reservation tracker.
// Addresses and IDs are carried at fixed maximum widths internally; narrower configurations
// zero-extend, so the unused upper bits stay constant and fold away.
package axi_lrsc_reservation_tracker_pkg;

    localparam int unsigned MAX_ADDR_W = 64;
    localparam int unsigned MAX_ID_W   = 32;
    localparam int unsigned TIMER_W    = 32;

    typedef logic [MAX_ADDR_W-1:0] tag_t;
    typedef logic [MAX_ADDR_W:0]   addr_ext_t;
    typedef logic [MAX_ID_W-1:0]   id_t;

    typedef struct packed {
        logic                valid;
        id_t                 id;
        tag_t                tag;
        logic [TIMER_W-1:0]  timer;
    } res_entry_t;

    // Granule index of a byte address.
    function automatic tag_t granule_tag(input tag_t addr, input int unsigned glog2);
        return addr >> glog2;
    endfunction

    // Last byte touched by an INCR burst, computed one bit wider so it cannot wrap,
    // then clamped to the top of the configured address space.
    function automatic tag_t burst_end(input tag_t addr, input logic [7:0] len,
                                       input logic [2:0] size, input int unsigned addr_w);
        addr_ext_t bytes;
        addr_ext_t last;
        addr_ext_t limit;
        bytes = (addr_ext_t'(len) + addr_ext_t'(1)) << size;
        last  = addr_ext_t'(addr) + bytes - addr_ext_t'(1);
        limit = (addr_ext_t'(1) << addr_w) - addr_ext_t'(1);
        if (last > limit) begin
            last = limit;
        end
        return last[MAX_ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/axi_lrsc_reservation_tracker_if.sv
// Sideband bundle between the atomics path and the reservation tracker.
interface axi_lrsc_reservation_tracker_if #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 10,
    parameter int unsigned NUM_RES        = 4
);
    localparam int unsigned CW = $clog2(NUM_RES + 1);

    logic                      lr_valid_i;
    logic                      lr_ready_o;
    logic [AXI_ID_WIDTH-1:0]   lr_id_i;
    logic [AXI_ADDR_WIDTH-1:0] lr_addr_i;

    logic                      sc_valid_i;
    logic                      sc_ready_o;
    logic [AXI_ID_WIDTH-1:0]   sc_id_i;
    logic [AXI_ADDR_WIDTH-1:0] sc_addr_i;

    logic                      sc_resp_valid_o;
    logic                      sc_resp_ok_o;
    logic [AXI_ID_WIDTH-1:0]   sc_resp_id_o;
    logic                      sc_resp_ready_i;

    logic                      wr_valid_i;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr_i;
    logic [7:0]                wr_len_i;
    logic [2:0]                wr_size_i;

    logic [CW-1:0]             res_count_o;

    modport slave (
        input  lr_valid_i, lr_id_i, lr_addr_i,
        input  sc_valid_i, sc_id_i, sc_addr_i, sc_resp_ready_i,
        input  wr_valid_i, wr_addr_i, wr_len_i, wr_size_i,
        output lr_ready_o, sc_ready_o, sc_resp_valid_o, sc_resp_ok_o, sc_resp_id_o,
        output res_count_o
    );

    modport master (
        output lr_valid_i, lr_id_i, lr_addr_i,
        output sc_valid_i, sc_id_i, sc_addr_i, sc_resp_ready_i,
        output wr_valid_i, wr_addr_i, wr_len_i, wr_size_i,
        input  lr_ready_o, sc_ready_o, sc_resp_valid_o, sc_resp_ok_o, sc_resp_id_o,
        input  res_count_o
    );

endinterface

// File: rtl/axi_lrsc_reservation_tracker_range_match.sv
// Overlap test between one reservation granule and a write's granule span.
// Working in granule units makes partial-granule overlap at either end count as a hit.
module axi_lrsc_reservation_tracker_range_match
    import axi_lrsc_reservation_tracker_pkg::*;
(
    input  tag_t i_tag,
    input  tag_t i_start_tag,
    input  tag_t i_end_tag,
    output logic o_hit
);

    // Inclusive range compare on granule indices.
    always_comb begin
        o_hit = (i_tag >= i_start_tag) && (i_tag <= i_end_tag);
    end

endmodule

// File: rtl/axi_lrsc_reservation_tracker.sv
// Multi-entry LR/SC reservation table keyed by AXI ID.
// Each cycle applies, in order: write snoop and expiry, SC check, LR allocate.
// Supports AXI_ADDR_WIDTH <= 64 and AXI_ID_WIDTH <= 32.
module axi_lrsc_reservation_tracker
    import axi_lrsc_reservation_tracker_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 10,
    parameter int unsigned NUM_RES        = 4,
    parameter int unsigned GRANULE_LOG2   = 3,
    parameter int unsigned RES_TIMEOUT    = 0
) (
    input logic                         CLK,
    input logic                         aresetn,
    axi_lrsc_reservation_tracker_if.slave bus
);

    localparam int unsigned VW = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;
    localparam int unsigned CW = $clog2(NUM_RES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(RES_TIMEOUT);

    res_entry_t              r_entry [NUM_RES];
    logic [VW-1:0]           r_victim;
    logic [CW-1:0]           r_count;
    logic                    r_active;
    logic                    r_resp_valid;
    logic                    r_resp_ok;
    logic [AXI_ID_WIDTH-1:0] r_resp_id;

    res_entry_t              w_ent_snp [NUM_RES];
    res_entry_t              w_ent_sc  [NUM_RES];
    res_entry_t              w_ent_lr  [NUM_RES];
    logic [NUM_RES-1:0]      w_snoop_hit;
    tag_t                    w_lr_tag;
    tag_t                    w_sc_tag;
    tag_t                    w_wr_start_tag;
    tag_t                    w_wr_end_tag;
    id_t                     w_lr_id;
    id_t                     w_sc_id;
    logic                    w_sc_ready;
    logic                    w_sc_fire;
    logic                    w_lr_fire;
    logic                    w_sc_ok;
    logic                    w_lr_found;
    logic [VW-1:0]           w_lr_idx;
    logic                    w_free_found;
    logic [VW-1:0]           w_free_idx;
    logic [VW-1:0]           w_sel_idx;
    logic [VW-1:0]           w_victim_d;
    logic [CW-1:0]           w_count_d;

    assign w_lr_id        = id_t'(bus.lr_id_i);
    assign w_sc_id        = id_t'(bus.sc_id_i);
    assign w_lr_tag       = granule_tag(tag_t'(bus.lr_addr_i), GRANULE_LOG2);
    assign w_sc_tag       = granule_tag(tag_t'(bus.sc_addr_i), GRANULE_LOG2);
    assign w_wr_start_tag = granule_tag(tag_t'(bus.wr_addr_i), GRANULE_LOG2);
    assign w_wr_end_tag   = granule_tag(burst_end(tag_t'(bus.wr_addr_i), bus.wr_len_i,
                                                  bus.wr_size_i, AXI_ADDR_WIDTH), GRANULE_LOG2);

    // r_active keeps both ready outputs low while in reset and until the first clock after it.
    assign w_sc_ready = r_active & (~r_resp_valid | bus.sc_resp_ready_i);
    assign w_sc_fire  = bus.sc_valid_i & w_sc_ready;
    assign w_lr_fire  = bus.lr_valid_i & r_active;

    assign bus.lr_ready_o      = r_active;
    assign bus.sc_ready_o      = w_sc_ready;
    assign bus.sc_resp_valid_o = r_resp_valid;
    assign bus.sc_resp_ok_o    = r_resp_ok;
    assign bus.sc_resp_id_o    = r_resp_id;
    assign bus.res_count_o     = r_count;

    for (genvar g = 0; g < NUM_RES; g++) begin : g_snoop
        axi_lrsc_reservation_tracker_range_match u_match (
            .i_tag       (r_entry[g].tag),
            .i_start_tag (w_wr_start_tag),
            .i_end_tag   (w_wr_end_tag),
            .o_hit       (w_snoop_hit[g])
        );
    end

    // Step 1: age timers and drop entries hit by a committed write.
    always_comb begin
        for (int i = 0; i < NUM_RES; i++) begin
            w_ent_snp[i] = r_entry[i];
            if ((RES_TIMEOUT != 0) && r_entry[i].valid) begin
                w_ent_snp[i].timer = r_entry[i].timer - TIMER_W'(1);
                if (r_entry[i].timer == TIMER_W'(1)) begin
                    w_ent_snp[i].valid = 1'b0;
                end
            end
            if (bus.wr_valid_i && w_snoop_hit[i]) begin
                w_ent_snp[i].valid = 1'b0;
            end
        end
    end

    // Step 2: SC verdict on the snooped table; the requester's entry is consumed either way.
    always_comb begin
        w_sc_ok = 1'b0;
        for (int i = 0; i < NUM_RES; i++) begin
            w_ent_sc[i] = w_ent_snp[i];
            if (w_sc_fire && w_ent_snp[i].valid && (w_ent_snp[i].id == w_sc_id)) begin
                if (w_ent_snp[i].tag == w_sc_tag) begin
                    w_sc_ok = 1'b1;
                end
                w_ent_sc[i].valid = 1'b0;
            end
        end
    end

    // Step 3: LR picks same-ID entry, else lowest free, else round-robin victim.
    always_comb begin
        w_lr_found   = 1'b0;
        w_lr_idx     = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = 0; i < NUM_RES; i++) begin
            if (!w_lr_found && w_ent_sc[i].valid && (w_ent_sc[i].id == w_lr_id)) begin
                w_lr_found = 1'b1;
                w_lr_idx   = VW'(i);
            end
            if (!w_free_found && !w_ent_sc[i].valid) begin
                w_free_found = 1'b1;
                w_free_idx   = VW'(i);
            end
        end
        w_sel_idx  = w_lr_found ? w_lr_idx : (w_free_found ? w_free_idx : r_victim);
        w_victim_d = r_victim;
        if (w_lr_fire && !w_lr_found && !w_free_found) begin
            w_victim_d = (r_victim == VW'(NUM_RES - 1)) ? '0 : r_victim + VW'(1);
        end
        w_count_d = '0;
        for (int i = 0; i < NUM_RES; i++) begin
            w_ent_lr[i] = w_ent_sc[i];
            if (w_lr_fire && (w_sel_idx == VW'(i))) begin
                w_ent_lr[i].valid = 1'b1;
                w_ent_lr[i].id    = w_lr_id;
                w_ent_lr[i].tag   = w_lr_tag;
                w_ent_lr[i].timer = TIMER_LOAD;
            end
            w_count_d = w_count_d + CW'(w_ent_lr[i].valid);
        end
    end

    // Reservation table, victim pointer and registered occupancy.
    always_ff @(posedge CLK or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_RES; i++) begin
                r_entry[i] <= '0;
            end
            r_victim <= '0;
            r_count  <= '0;
        end else begin
            for (int i = 0; i < NUM_RES; i++) begin
                r_entry[i] <= w_ent_lr[i];
            end
            r_victim <= w_victim_d;
            r_count  <= w_count_d;
        end
    end

    // SC verdict register: loads on accept, holds until consumed.
    always_ff @(posedge CLK or negedge aresetn) begin
        if (!aresetn) begin
            r_active     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_ok    <= 1'b0;
            r_resp_id    <= '0;
        end else begin
            r_active <= 1'b1;
            if (w_sc_fire) begin
                r_resp_valid <= 1'b1;
                r_resp_ok    <= w_sc_ok;
                r_resp_id    <= bus.sc_id_i;
            end else if (bus.sc_resp_ready_i) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

endmodule
